// File: rtl/cdb_result_arbiter.sv
// cdb_result_arbiter: per-source result FIFOs with round-robin grants onto two registered CDB slots
module cdb_result_arbiter #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  int_valid,
  input  logic [DATA_W-1:0]     int_data,
  output logic                  int_ready,
  input  logic                  ls_valid,
  input  logic [DATA_W-1:0]     ls_data,
  output logic                  ls_ready,
  input  logic                  mul_valid,
  input  logic [DATA_W-1:0]     mul_data,
  output logic                  mul_ready,
  input  logic [1:0]            slot_en,
  output logic [2*DATA_W+1:0]   CDBData,
  output logic [2:0]            clearRSEntry,
  output logic [1:0]            rr_ptr
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = DATA_W + 1;

  logic [DATA_W-1:0] mem_q [3][DEPTH];
  logic [DATA_W-1:0] mem_d [3][DEPTH];
  logic [PW-1:0]     wp_q [3], wp_d [3], rp_q [3], rp_d [3];
  logic [CW-1:0]     cnt_q [3], cnt_d [3];
  logic [2*SW-1:0]   cdb_q, cdb_d;
  logic [2:0]        clr_q, clr_d;
  logic [1:0]        rr_q, rr_d;
  logic [2:0]        vld, rdy, push, grant;
  logic [DATA_W-1:0] din [3];
  logic [DATA_W-1:0] head [3];
  logic [1:0]        n_en, ng, idx, last;
  logic [2:0]        s;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign vld    = {mul_valid, ls_valid, int_valid};
  assign din[0] = int_data;
  assign din[1] = ls_data;
  assign din[2] = mul_data;
  assign push   = vld & rdy;

  for (genvar i = 0; i < 3; i++) begin : g_src
    // Ready looks only at the registered count, so a full FIFO refuses even while popping.
    assign rdy[i]  = !rst && (cnt_q[i] < CW'(DEPTH));
    assign head[i] = mem_q[i][rp_q[i]];
  end

  always_comb begin
    grant = '0;
    cdb_d = '0;
    ng    = '0;
    last  = rr_q;
    s     = '0;
    idx   = '0;
    n_en  = {1'b0, slot_en[0]} + {1'b0, slot_en[1]};
    for (int k = 0; k < 3; k++) begin
      s   = {1'b0, rr_q} + 3'(k);
      idx = s >= 3'd3 ? 2'(s - 3'd3) : s[1:0];
      if (cnt_q[idx] != '0 && ng < n_en) begin
        grant[idx] = 1'b1;
        last       = idx;
        if (ng == 2'd0 && slot_en[0]) cdb_d[SW-1:0] = {1'b1, head[idx]};
        else cdb_d[2*SW-1:SW] = {1'b1, head[idx]};
        ng = ng + 2'd1;
      end
    end
    clr_d = grant;
    rr_d  = grant != '0 ? (last == 2'd2 ? 2'd0 : last + 2'd1) : rr_q;
  end

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (push[i]) begin
        mem_d[i][wp_q[i]] = din[i];
        wp_d[i] = inc(wp_q[i]);
      end
      if (grant[i]) rp_d[i] = inc(rp_q[i]);
      cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(grant[i]);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wp_q  <= '{default: '0};
      rp_q  <= '{default: '0};
      cnt_q <= '{default: '0};
      cdb_q <= '0;
      clr_q <= '0;
      rr_q  <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      cdb_q <= cdb_d;
      clr_q <= clr_d;
      rr_q  <= rr_d;
    end
  end

  assign int_ready    = rdy[0];
  assign ls_ready     = rdy[1];
  assign mul_ready    = rdy[2];
  assign CDBData      = cdb_q;
  assign clearRSEntry = clr_q;
  assign rr_ptr       = rr_q;
endmodule

// File: tb/tb_cdb_result_arbiter.sv
// tb_cdb_result_arbiter: directed vectors with hand-computed CDB, grant and pointer values
module tb_cdb_result_arbiter;
  logic        clk = 0, rst = 1;
  logic        int_valid = 0, ls_valid = 0, mul_valid = 0;
  logic [19:0] int_data = 0, ls_data = 0, mul_data = 0;
  logic        int_ready, ls_ready, mul_ready;
  logic [1:0]  slot_en = 2'b11;
  logic [41:0] CDBData;
  logic [2:0]  clearRSEntry;
  logic [1:0]  rr_ptr;
  int pass_cnt = 0, total_cnt = 0;

  cdb_result_arbiter dut (
    .clk(clk), .rst(rst),
    .int_valid(int_valid), .int_data(int_data), .int_ready(int_ready),
    .ls_valid(ls_valid), .ls_data(ls_data), .ls_ready(ls_ready),
    .mul_valid(mul_valid), .mul_data(mul_data), .mul_ready(mul_ready),
    .slot_en(slot_en), .CDBData(CDBData), .clearRSEntry(clearRSEntry), .rr_ptr(rr_ptr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else pass_cnt++;
  endtask

  task automatic out_chk(input string tag, input logic [41:0] cdb, input logic [2:0] clr, input logic [1:0] rr);
    check({tag, "_cdb"}, 64'(CDBData), 64'(cdb));
    check({tag, "_clr"}, 64'(clearRSEntry), 64'(clr));
    check({tag, "_rr"}, 64'(rr_ptr), 64'(rr));
  endtask

  initial begin
    // T1: reset with every source offering
    int_valid = 1; ls_valid = 1; mul_valid = 1;
    int_data = 20'hdead0; ls_data = 20'hdead1; mul_data = 20'hdead2;
    tick();
    tick();
    check("t1_ready", 64'({mul_ready, ls_ready, int_ready}), 64'(3'b000));
    out_chk("t1", 42'h0, 3'b000, 2'd0);
    rst = 0; int_valid = 0; ls_valid = 0; mul_valid = 0;
    #1;
    check("t1_ready_after", 64'({mul_ready, ls_ready, int_ready}), 64'(3'b111));
    tick();
    out_chk("t1_empty", 42'h0, 3'b000, 2'd0);
    // T2: single INT result
    int_valid = 1; int_data = 20'h12345;
    tick();
    int_valid = 0;
    out_chk("t2_lat", 42'h0, 3'b000, 2'd0);
    tick();
    out_chk("t2", {21'h0, 21'h112345}, 3'b001, 2'd1);
    tick();
    out_chk("t2_idle", 42'h0, 3'b000, 2'd1);
    // MUL alone moves the pointer back to INT
    mul_valid = 1; mul_data = 20'h00aaa;
    tick();
    mul_valid = 0;
    tick();
    out_chk("t3_pre", {21'h0, 1'b1, 20'h00aaa}, 3'b100, 2'd0);
    // T3: three-way contention
    int_valid = 1; ls_valid = 1; mul_valid = 1;
    int_data = 20'h11111; ls_data = 20'h22222; mul_data = 20'h33333;
    tick();
    int_valid = 0; ls_valid = 0; mul_valid = 0;
    tick();
    out_chk("t3_c1", {1'b1, 20'h22222, 1'b1, 20'h11111}, 3'b011, 2'd2);
    tick();
    out_chk("t3_c2", {21'h0, 1'b1, 20'h33333}, 3'b100, 2'd0);
    // T4: backpressure with no slots
    slot_en = 2'b00; mul_valid = 1; mul_data = 20'ha0001;
    check("t4_rdy0", 64'(mul_ready), 64'(1'b1));
    tick();
    mul_data = 20'ha0002;
    out_chk("t4_hold", 42'h0, 3'b000, 2'd0);
    tick();
    check("t4_full", 64'(mul_ready), 64'(1'b0));
    mul_data = 20'ha0003;
    tick();
    check("t4_full2", 64'(mul_ready), 64'(1'b0));
    mul_data = 20'ha0004;
    tick();
    mul_valid = 0; slot_en = 2'b01;
    out_chk("t4_nogrant", 42'h0, 3'b000, 2'd0);
    tick();
    out_chk("t4_d1", {21'h0, 1'b1, 20'ha0001}, 3'b100, 2'd0);
    check("t4_rdy_back", 64'(mul_ready), 64'(1'b1));
    tick();
    out_chk("t4_d2", {21'h0, 1'b1, 20'ha0002}, 3'b100, 2'd0);
    tick();
    out_chk("t4_drained", 42'h0, 3'b000, 2'd0);
    // T5: upper slot only
    slot_en = 2'b10; ls_valid = 1; mul_valid = 1;
    ls_data = 20'h5aaaa; mul_data = 20'h6bbbb;
    tick();
    ls_valid = 0; mul_valid = 0;
    tick();
    out_chk("t5_ls", {1'b1, 20'h5aaaa, 21'h0}, 3'b010, 2'd2);
    tick();
    out_chk("t5_mul", {1'b1, 20'h6bbbb, 21'h0}, 3'b100, 2'd0);
    // T6: reset with all FIFOs full
    slot_en = 2'b00; int_valid = 1; ls_valid = 1; mul_valid = 1;
    int_data = 20'h70001; ls_data = 20'h70002; mul_data = 20'h70003;
    tick();
    tick();
    int_valid = 0; ls_valid = 0; mul_valid = 0;
    check("t6_full", 64'({mul_ready, ls_ready, int_ready}), 64'(3'b000));
    rst = 1; slot_en = 2'b11;
    tick();
    out_chk("t6_rst", 42'h0, 3'b000, 2'd0);
    check("t6_rst_ready", 64'({mul_ready, ls_ready, int_ready}), 64'(3'b000));
    rst = 0;
    #1;
    check("t6_ready", 64'({mul_ready, ls_ready, int_ready}), 64'(3'b111));
    tick();
    out_chk("t6_empty", 42'h0, 3'b000, 2'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
